shift_reg_8_sched: RTL
======================

Name: shift_reg_8_sched

Overview:
- Round-robin scheduler that shares one shift_reg_8 datapath (4-bit async parallel load into Q0..Q3, Q4..Q7 cleared, zero-fill shift toward Q7 on each SHIFT rising edge) between two requesters.
- Per job: latches a nibble and a shift amount, pulses LOAD, emits AMT SHIFT pulses, captures Q[7:0] and returns it with a done pulse.
- Sits between the tile's input decode and the shift_reg_8 instance; it is the only driver of that instance's LOAD and SHIFT.

Parameters:
- PULSE_W, 1, clocks SHIFT is held high and then low per shift pulse (legal 1..4).

Ports:
- CLK  in  1  system clock; all state updates on rising edge.
- RST_N  in  1  asynchronous active-low reset.
- REQ0  in  1  requester 0 job request, level, held until DONE0.
- D0_IN  in  4  requester 0 nibble.
- AMT0  in  3  requester 0 shift amount, 0..7.
- REQ1  in  1  requester 1 job request.
- D1_IN  in  4  requester 1 nibble.
- AMT1  in  3  requester 1 shift amount.
- Q  in  8  shift_reg_8 outputs Q7..Q0 (Q[0]=Q0).
- LOAD  out  1  to shift_reg_8 LOAD.
- SHIFT  out  1  to shift_reg_8 SHIFT (used as its clock).
- LD_DATA  out  4  to shift_reg_8 D3..D0.
- GNT0, GNT1  out  1  grant level, high from grant until the DONE cycle inclusive.
- DONE0, DONE1  out  1  one-cycle completion pulse.
- BUSY  out  1  high in every state except IDLE.
- RESULT  out  8  captured Q, valid from the DONE cycle until the next capture.

Behaviour:
- Reset (async, RST_N=0): state=IDLE; LOAD, SHIFT, GNT*, DONE*, BUSY=0; RESULT=8'h00; LD_DATA=0; LAST=1 (requester 0 wins the first tie); counters=0. Release is synchronous to the next CLK edge.
- All outputs are registered; no combinational path from inputs to outputs.
- States: IDLE, LOAD, GAP, SH_HI, SH_LO, CAPT, DONE.
- IDLE: if any REQ is high, choose a winner, latch its D/AMT into LD_DATA/cnt, set the matching GNT, go to LOAD.
  - Tie: winner = requester != LAST; LAST <= winner.
  - Single request: that requester wins.
- LOAD: LOAD=1 for exactly 1 cycle -> GAP.
- GAP: LOAD=0 for 1 cycle. Guarantees the async preset/reset is released before any SHIFT edge. cnt==0 -> CAPT, else -> SH_HI.
- SH_HI: SHIFT=1 for PULSE_W cycles -> SH_LO.
- SH_LO: SHIFT=0 for PULSE_W cycles; cnt decrements on exit; cnt==0 after the decrement -> CAPT, else -> SH_HI.
- CAPT: RESULT <= Q -> DONE.
- DONE: DONEx=1 and GNTx=1 for 1 cycle; then GNT clears -> IDLE.
  - A request still high is rearbitrated in IDLE on the next cycle (one idle cycle between jobs).
- Latency from the grant edge to the DONE pulse: 3 + 2*PULSE_W*AMT cycles (grant cycle = LOAD cycle).
- Expected result: RESULT = ({4'b0,D} << AMT) & 8'hFF. AMT >= 5 drops D3 upward; AMT=7 leaves only D0 at Q7.
- REQ dropped mid-job: the job runs to completion and DONE still pulses. D/AMT changes after the grant are ignored.
- Loser of a tie stays pending; it is served next regardless of whether the winner re-requests (no starvation).
- Reset mid-job: LOAD and SHIFT go low immediately. shift_reg_8 contents are not cleared. RESULT returns to 0.
- SHIFT never toggles while LOAD=1. LOAD never asserts while SHIFT=1.

Test Plan:
- Reset: RST_N low mid-SH_HI -> SHIFT, LOAD, BUSY, GNT*=0 and RESULT=00 within the same cycle (async). After release, IDLE with no activity.
- Single job, PULSE_W=1: REQ0=1, D0_IN=4'hB, AMT0=2 -> LOAD 1 cycle, 2 SHIFT pulses, RESULT=8'h2C, DONE0 exactly 7 cycles after the grant edge.
- AMT=0 and AMT=7: D=4'h9, AMT=0 -> RESULT=8'h09, no SHIFT pulses, DONE at +3. D=4'h9, AMT=7 -> RESULT=8'h80.
- Tie and fairness: REQ0=REQ1=1 from reset, held -> grant order 0,1,0,1. Each DONE pulses only on its own requester's line. RESULTs match each requester's data.
- Drop mid-job: REQ1 lowered during SH_LO (D=4'h3, AMT=3) -> job completes, RESULT=8'h18, DONE1 pulses, no regrant.
- PULSE_W=3 build: D=4'h1, AMT=1 -> SHIFT high exactly 3 cycles, RESULT=8'h02, DONE at +9.

Source files
------------

// File: rtl/shift_reg_8_sched.sv
// Round-robin scheduler sharing one shift_reg_8 between two requesters.
// Per job: load a nibble, emit AMT shift pulses, capture Q, pulse done.
module shift_reg_8_sched #(
    parameter int PULSE_W = 1
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       req0_i,
    input  logic [3:0] d0_i,
    input  logic [2:0] amt0_i,
    input  logic       req1_i,
    input  logic [3:0] d1_i,
    input  logic [2:0] amt1_i,
    input  logic [7:0] q_i,
    output logic       load_o,
    output logic       shift_o,
    output logic [3:0] ld_data_o,
    output logic       gnt0_o,
    output logic       gnt1_o,
    output logic       done0_o,
    output logic       done1_o,
    output logic       busy_o,
    output logic [7:0] result_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_GAP,
        S_SH_HI,
        S_SH_LO,
        S_CAPT,
        S_DONE
    } state_e;

    localparam logic [1:0] PW_LAST = 2'(PULSE_W - 1);

    state_e     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic [1:0] pw_q, pw_d;
    logic       owner_q, owner_d;
    logic       last_q, last_d;
    logic       load_q, load_d;
    logic       shift_q, shift_d;
    logic [3:0] ld_data_q, ld_data_d;
    logic       gnt0_q, gnt0_d;
    logic       gnt1_q, gnt1_d;
    logic       done0_q, done0_d;
    logic       done1_q, done1_d;
    logic       busy_q, busy_d;
    logic [7:0] result_q, result_d;
    logic       win;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pw_d      = pw_q;
        owner_d   = owner_q;
        last_d    = last_q;
        load_d    = load_q;
        shift_d   = shift_q;
        ld_data_d = ld_data_q;
        gnt0_d    = gnt0_q;
        gnt1_d    = gnt1_q;
        done0_d   = 1'b0;
        done1_d   = 1'b0;
        busy_d    = busy_q;
        result_d  = result_q;
        // On a tie the requester that did not win last time is served.
        win       = (req0_i && req1_i) ? ~last_q : req1_i;
        unique case (state_q)
            S_IDLE: begin
                if (req0_i || req1_i) begin
                    owner_d   = win;
                    last_d    = win;
                    ld_data_d = win ? d1_i : d0_i;
                    cnt_d     = win ? amt1_i : amt0_i;
                    gnt0_d    = ~win;
                    gnt1_d    = win;
                    busy_d    = 1'b1;
                    load_d    = 1'b1;
                    state_d   = S_LOAD;
                end
            end
            S_LOAD: begin
                load_d  = 1'b0;
                state_d = S_GAP;
            end
            S_GAP: begin
                pw_d = 2'd0;
                if (cnt_q == 3'd0) begin
                    state_d = S_CAPT;
                end else begin
                    shift_d = 1'b1;
                    state_d = S_SH_HI;
                end
            end
            S_SH_HI: begin
                if (pw_q == PW_LAST) begin
                    pw_d    = 2'd0;
                    shift_d = 1'b0;
                    state_d = S_SH_LO;
                end else begin
                    pw_d = pw_q + 2'd1;
                end
            end
            S_SH_LO: begin
                if (pw_q == PW_LAST) begin
                    pw_d  = 2'd0;
                    cnt_d = cnt_q - 3'd1;
                    if (cnt_q == 3'd1) begin
                        state_d = S_CAPT;
                    end else begin
                        shift_d = 1'b1;
                        state_d = S_SH_HI;
                    end
                end else begin
                    pw_d = pw_q + 2'd1;
                end
            end
            S_CAPT: begin
                result_d = q_i;
                done0_d  = ~owner_q;
                done1_d  = owner_q;
                state_d  = S_DONE;
            end
            S_DONE: begin
                gnt0_d  = 1'b0;
                gnt1_d  = 1'b0;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                load_d  = 1'b0;
                shift_d = 1'b0;
                gnt0_d  = 1'b0;
                gnt1_d  = 1'b0;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= S_IDLE;
            cnt_q     <= 3'd0;
            pw_q      <= 2'd0;
            owner_q   <= 1'b0;
            last_q    <= 1'b1;
            load_q    <= 1'b0;
            shift_q   <= 1'b0;
            ld_data_q <= 4'd0;
            gnt0_q    <= 1'b0;
            gnt1_q    <= 1'b0;
            done0_q   <= 1'b0;
            done1_q   <= 1'b0;
            busy_q    <= 1'b0;
            result_q  <= 8'h00;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pw_q      <= pw_d;
            owner_q   <= owner_d;
            last_q    <= last_d;
            load_q    <= load_d;
            shift_q   <= shift_d;
            ld_data_q <= ld_data_d;
            gnt0_q    <= gnt0_d;
            gnt1_q    <= gnt1_d;
            done0_q   <= done0_d;
            done1_q   <= done1_d;
            busy_q    <= busy_d;
            result_q  <= result_d;
        end
    end

    assign load_o    = load_q;
    assign shift_o   = shift_q;
    assign ld_data_o = ld_data_q;
    assign gnt0_o    = gnt0_q;
    assign gnt1_o    = gnt1_q;
    assign done0_o   = done0_q;
    assign done1_o   = done1_q;
    assign busy_o    = busy_q;
    assign result_o  = result_q;

endmodule
